// File: rtl/nf10_upb_debug_capture_if.sv
// rtl/nf10_upb_debug_capture_if.sv - synchronous buffer read port for the debug capture core
interface nf10_upb_debug_capture_if #(
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_W       = 64
) ();
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic                  rd_en;
    logic [RD_W-1:0]       rd_data;
    logic                  rd_valid;

    modport master (
        output rd_addr,
        output rd_en,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  rd_addr,
        input  rd_en,
        output rd_data,
        output rd_valid
    );
endinterface

// File: rtl/nf10_upb_debug_capture.sv
// rtl/nf10_upb_debug_capture.sv - circular-buffer debug capture around a masked trigger; optional CAPTURE_TIMESTAMP_EN
module nf10_upb_debug_capture #(
    parameter int CHANNELS    = 4,
    parameter int PROBE_WIDTH = 64,
    parameter int DEPTH_LOG2  = 10
) (
    input  logic                                          axi_aclk,
    input  logic                                          axi_aresetn,
    input  logic [CHANNELS*PROBE_WIDTH-1:0]               probe,
    input  logic [CHANNELS-1:0]                           probe_valid,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] ch_sel,
    input  logic                                          arm,
    input  logic                                          abort,
    input  logic [PROBE_WIDTH-1:0]                        trig_value,
    input  logic [PROBE_WIDTH-1:0]                        trig_mask,
    input  logic [DEPTH_LOG2-1:0]                         pre_trig,
    output logic                                          busy,
    output logic                                          triggered,
    output logic                                          done,
    output logic [DEPTH_LOG2-1:0]                         trig_ptr,
    nf10_upb_debug_capture_if.slave                       rd_if
);

    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef CAPTURE_TIMESTAMP_EN
    localparam int MEM_W = PROBE_WIDTH + 32;
`else
    localparam int MEM_W = PROBE_WIDTH;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT,
        S_POST,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [SEL_W-1:0]       sel_q;
    logic [DEPTH_LOG2-1:0]  pre_q;
    logic [DEPTH_LOG2-1:0]  wr_ptr_q;
    logic [DEPTH_LOG2-1:0]  cnt_q;
    logic [DEPTH_LOG2-1:0]  post_q;
    logic [DEPTH_LOG2-1:0]  trig_ptr_q;
    logic                   busy_q;
    logic                   triggered_q;
    logic                   done_q;
    logic                   rd_valid_q;
    logic                   rd_seen_q;
    logic [MEM_W-1:0]       rd_word_q;
    logic [MEM_W-1:0]       mem_q [DEPTH];

    logic [PROBE_WIDTH-1:0] sample;
    logic                   sample_vld;
    logic                   hit;
    logic                   wr_en;
    logic [MEM_W-1:0]       wr_word;
    logic [DEPTH_LOG2-1:0]  post_d;
    logic [DEPTH_LOG2-1:0]  rd_phys;

    // Channel indices past CHANNELS-1 select nothing, so no sample is ever qualified.
    always_comb begin
        sample     = '0;
        sample_vld = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sel_q == SEL_W'(c)) begin
                sample     = probe[c*PROBE_WIDTH +: PROBE_WIDTH];
                sample_vld = probe_valid[c];
            end
        end
    end

    assign hit     = ((sample ^ trig_value) & trig_mask) == '0;
    assign wr_en   = sample_vld &&
                     ((state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST));
    assign post_d  = {DEPTH_LOG2{1'b1}} - pre_q;
    assign rd_phys = trig_ptr_q - pre_q + rd_if.rd_addr;

`ifdef CAPTURE_TIMESTAMP_EN
    logic [31:0] ts_q;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
        end
    end

    assign wr_word = {ts_q, sample};
`else
    assign wr_word = sample;
`endif

    // Buffer kept free of reset so it maps onto a simple dual-port block RAM.
    always_ff @(posedge axi_aclk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
        if (rd_if.rd_en) begin
            rd_word_q <= mem_q[rd_phys];
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rd_valid_q <= 1'b0;
            rd_seen_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_if.rd_en;
            if (rd_if.rd_en) begin
                rd_seen_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            pre_q       <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            post_q      <= '0;
            trig_ptr_q  <= '0;
            busy_q      <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
        end else if (abort && (state_q != S_IDLE)) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm && !abort) begin
                        sel_q       <= ch_sel;
                        pre_q       <= pre_trig;
                        wr_ptr_q    <= '0;
                        cnt_q       <= '0;
                        triggered_q <= 1'b0;
                        done_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= (pre_trig == '0) ? S_WAIT : S_PRE;
                    end
                end
                S_PRE: begin
                    if (sample_vld) begin
                        wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
                        cnt_q    <= cnt_q + DEPTH_LOG2'(1);
                        if ((cnt_q + DEPTH_LOG2'(1)) == pre_q) begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (sample_vld) begin
                        wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
                        if (hit) begin
                            trig_ptr_q  <= wr_ptr_q;
                            triggered_q <= 1'b1;
                            post_q      <= post_d;
                            if (post_d == '0) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_POST;
                            end
                        end
                    end
                end
                S_POST: begin
                    if (sample_vld) begin
                        wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
                        post_q   <= post_q - DEPTH_LOG2'(1);
                        if (post_q == DEPTH_LOG2'(1)) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign triggered      = triggered_q;
    assign done           = done_q;
    assign trig_ptr       = trig_ptr_q;
    assign rd_if.rd_valid = rd_valid_q;
    assign rd_if.rd_data  = rd_seen_q ? rd_word_q : '0;

endmodule

// File: doc/nf10_upb_debug_capture.md
# nf10_upb_debug_capture

On-chip debug capture core: the vendor-independent, parametrised successor to the ChipScope ICON/ILA pairing. It captures one of CHANNELS probe buses into a circular sample buffer around a masked-compare trigger, with a programmable pre-trigger depth. Results are read back through a simple synchronous read port from a register-bank wrapper. It sits beside the datapath cores and needs no JTAG or black-box netlist.

## Interface
Parameters:
- CHANNELS, 4, number of probe buses; must be 1 to 16.
- PROBE_WIDTH, 64, bits per probe bus.
- DEPTH_LOG2, 10, log2 of buffer depth; DEPTH = 2^DEPTH_LOG2 samples.

Ports:
- axi_aclk  in  1  sole clock.
- axi_aresetn  in  1  asynchronous, active-low reset.
- probe  in  CHANNELS*PROBE_WIDTH  channel c occupies [c*PROBE_WIDTH +: PROBE_WIDTH].
- probe_valid  in  CHANNELS  per-channel sample qualifier.
- ch_sel  in  max(1,clog2(CHANNELS))  channel to capture; latched on arm.
- arm  in  1  single-cycle start pulse.
- abort  in  1  cancels a capture in progress.
- trig_value  in  PROBE_WIDTH  trigger compare value; sampled live.
- trig_mask  in  PROBE_WIDTH  1 = bit participates in the compare; sampled live.
- pre_trig  in  DEPTH_LOG2  samples to retain before the trigger; latched on arm.
- busy  out  1  high in the PRE, WAIT and POST states.
- triggered  out  1  high from trigger until the next arm, abort or reset.
- done  out  1  high in the DONE state.
- trig_ptr  out  DEPTH_LOG2  physical buffer address of the trigger sample.
- rd_addr  in  DEPTH_LOG2  logical read address; 0 = oldest sample.
- rd_en  in  1  read strobe.
- rd_data  out  PROBE_WIDTH (+32 with timestamp)  read data.
- rd_valid  out  1  rd_data qualifier.

## Operation
- States: IDLE, PRE, WAIT, POST, DONE.
- A sample is the selected channel's probe bus in a cycle where probe_valid[sel] = 1. Each sample is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- IDLE, or DONE, on arm:
  - latch ch_sel and pre_trig;
  - set wr_ptr = 0 and cnt = 0;
  - clear triggered and done;
  - go to PRE, or to WAIT if pre_trig = 0.
- PRE: store samples, cnt++. When cnt reaches pre_trig, go to WAIT. The trigger is not evaluated in PRE.
- WAIT:
  - Store samples; the buffer overwrites circularly.
  - Trigger = valid sample with ((sample ^ trig_value) & trig_mask) == 0. A mask of all zeros triggers on the first valid sample.
  - On trigger: store the sample, set trig_ptr = wr_ptr, set triggered, and load post = DEPTH-1-pre_trig. Go to POST, or to DONE if post = 0.
- POST: store samples, post--. After the write that makes post 0, go to DONE.
- DONE: hold the buffer and pointers.
- arm in PRE, WAIT or POST is ignored.
- abort in any state other than IDLE returns to IDLE and clears triggered and done. If arm and abort occur in the same cycle, abort wins.
- Readout:
  - Physical address = (trig_ptr - pre_trig + rd_addr) mod DEPTH, so rd_addr = pre_trig returns the trigger sample.
  - Reads are legal in any state. Data is only meaningful while done = 1.
- Address arithmetic is DEPTH_LOG2 bits wide, unsigned, with natural wrap.

## Timing
- Reset: state IDLE; busy, triggered, done, rd_valid = 0; trig_ptr = 0; rd_data = 0. Reset during a capture discards it. Buffer contents are not cleared.
- A sample present at clock edge N is written at edge N. The trigger decision is made on that same edge, so the trigger sample is always stored.
- busy rises the cycle after arm. done rises the cycle after the final POST write (or after the trigger write when post = 0).
- Read latency is 1 cycle: rd_en at edge N gives rd_data and rd_valid at edge N+1. Back-to-back reads sustain one per cycle.
- The buffer uses a simple dual-port RAM, so the design infers block RAM.

## Configuration
- CAPTURE_TIMESTAMP_EN defined:
  - A free-running 32-bit cycle counter, reset to 0 and wrapping, is stored alongside each sample.
  - rd_data is PROBE_WIDTH+32 bits, with the timestamp in the upper 32 bits.
- Undefined: no counter is built, and rd_data is PROBE_WIDTH bits.

## Test plan
- CHANNELS=4, DEPTH_LOG2=4, ch_sel=2, pre_trig=4, mask=0xFF, value=0x0A; channel 2 counts 0x00..0x20 every cycle.
  - Required: done; trig_ptr=10; rd_addr 0..15 returns 0x06..0x15.
- pre_trig=0, trig_mask=0, with a valid sample after arm.
  - Required: trigger on the first valid sample; rd_addr 0 returns that sample; done after 16 samples.
- probe_valid[2] toggling every other cycle.
  - Required: only qualified samples are stored; the POST count advances only on valid cycles.
- abort in WAIT, then arm issued together with abort.
  - Required: IDLE in both cases; busy=0, done=0, triggered=0.
- axi_aresetn pulsed low mid-POST.
  - Required: all outputs 0 immediately; a new arm completes normally.
- With CAPTURE_TIMESTAMP_EN defined, capture with the sample valid every cycle.
  - Required: consecutive timestamps differ by 1, and by 2 when samples are valid every other cycle.
